// File: rtl/mul_seq.sv
// mul_seq: multi-cycle sequencer driving a combinational SIMD multiplier for even/odd passes
module mul_seq #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:63] req_op1,
    input  logic [0:63] req_op2,
    input  logic [1:0]  req_ww,
    input  logic [1:0]  req_mode,
    input  logic [0:4]  req_tag,
    output logic [0:63] mul_op1,
    output logic [0:63] mul_op2,
    output logic [1:0]  mul_ww,
    output logic        mul_oe,
    input  logic [0:63] mul_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:63] rsp_even,
    output logic [0:63] rsp_odd,
    output logic [0:4]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;
    state_t state, state_nx;
    logic [1:0]  cnt;
    logic [0:63] op1, op2, even, odd;
    logic [1:0]  ww, mode;
    logic [0:4]  tag;
    logic        err, acc, bad, last;
    assign acc  = req_valid & req_ready;
    assign bad  = (req_ww == 2'b11) | (req_mode == 2'b11);
    assign last = cnt == 2'd0;
    // next-state: illegal requests skip straight to DONE; mode 10 chains EVEN into ODD
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = acc ? (bad ? DONE : (req_mode == 2'b01 ? ODD : EVEN)) : IDLE;
            EVEN: state_nx = last ? (mode == 2'b10 ? ODD : DONE) : EVEN;
            ODD:  state_nx = last ? DONE : ODD;
            DONE: state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // operand latch, settle counter reloaded on each pass entry, and pass result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1  <= '0;
            op2  <= '0;
            ww   <= '0;
            mode <= '0;
            tag  <= '0;
            even <= '0;
            odd  <= '0;
            err  <= 1'b0;
            cnt  <= '0;
        end else begin
            if (acc) begin
                op1  <= req_op1;
                op2  <= req_op2;
                ww   <= req_ww;
                mode <= req_mode;
                tag  <= req_tag;
                even <= '0;
                odd  <= '0;
                err  <= bad;
            end
            if ((state_nx == EVEN || state_nx == ODD) && state_nx != state) cnt <= 2'(LAT - 1);
            else if (!last) cnt <= cnt - 2'd1;
            if (state == EVEN && last) even <= mul_out;
            if (state == ODD && last) odd <= mul_out;
        end
    end
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == DONE;
    assign mul_oe    = state == ODD;
    assign mul_op1   = op1;
    assign mul_op2   = op2;
    assign mul_ww    = ww;
    assign rsp_even  = even;
    assign rsp_odd   = odd;
    assign rsp_tag   = tag;
    assign rsp_err   = err;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq at LAT=1 and LAT=3 with a behavioural SIMD multiplier
module tb_mul_seq;
    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, rv_in = 1'b0, rsp_ready = 1'b0;
    logic [0:63] op1 = '0, op2 = '0;
    logic [1:0]  ww = '0, mode = '0;
    logic [0:4]  tag = '0;
    logic        rdy1, oe1, rv1, err1, busy1, rdy3, oe3, rv3, err3, busy3;
    logic [0:63] mop1_1, mop2_1, mo1, ev1, od1, mop1_3, mop2_3, mo3, ev3, od3;
    logic [1:0]  mww1, mww3;
    logic [0:4]  tg1, tg3;
    logic        rdy, oe, rv, err, busy;
    logic [0:63] ev, od;
    logic [0:4]  tg;
    int          nchk = 0, nerr = 0, lat;
    logic [31:0] oe_hist;
    always #5 clk = ~clk;

    function automatic logic [63:0] mdl(input logic [63:0] a, input logic [63:0] b, input logic [1:0] w_sel, input logic o);
        int w;
        logic [63:0] x, y, r;
        w = w_sel == 2'b00 ? 8 : w_sel == 2'b01 ? 16 : 32;
        r = '0;
        for (int j = 0; j < 32 / w; j++) begin
            x = (a << ((2 * j + int'(o)) * w)) >> (64 - w);
            y = (b << ((2 * j + int'(o)) * w)) >> (64 - w);
            r |= (x * y) << (64 - 2 * w * (j + 1));
        end
        return r;
    endfunction

    assign mo1 = mdl(mop1_1, mop2_1, mww1, oe1);
    assign mo3 = mdl(mop1_3, mop2_3, mww3, oe3);

    mul_seq #(.LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in & ~sel), .req_ready(rdy1),
        .req_op1(op1), .req_op2(op2), .req_ww(ww), .req_mode(mode), .req_tag(tag),
        .mul_op1(mop1_1), .mul_op2(mop2_1), .mul_ww(mww1), .mul_oe(oe1), .mul_out(mo1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_even(ev1), .rsp_odd(od1),
        .rsp_tag(tg1), .rsp_err(err1), .busy(busy1)
    );
    mul_seq #(.LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in & sel), .req_ready(rdy3),
        .req_op1(op1), .req_op2(op2), .req_ww(ww), .req_mode(mode), .req_tag(tag),
        .mul_op1(mop1_3), .mul_op2(mop2_3), .mul_ww(mww3), .mul_oe(oe3), .mul_out(mo3),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_even(ev3), .rsp_odd(od3),
        .rsp_tag(tg3), .rsp_err(err3), .busy(busy3)
    );

    assign rdy  = sel ? rdy3 : rdy1;
    assign oe   = sel ? oe3 : oe1;
    assign rv   = sel ? rv3 : rv1;
    assign err  = sel ? err3 : err1;
    assign busy = sel ? busy3 : busy1;
    assign ev   = sel ? ev3 : ev1;
    assign od   = sel ? od3 : od1;
    assign tg   = sel ? tg3 : tg1;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", t, got, exp);
        end
    endtask

    // call at a negedge; returns just after the accept edge
    task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [1:0] w, input logic [1:0] m, input logic [4:0] t);
        op1 = a; op2 = b; ww = w; mode = m; tag = t; rv_in = 1'b1;
        chk("req_ready_before_accept", rdy, 1);
        @(posedge clk);
        #1 rv_in = 1'b0;
    endtask

    task automatic wait_rsp();
        lat = 0;
        oe_hist = '0;
        do begin
            @(negedge clk);
            lat++;
            if (oe) oe_hist[lat] = 1'b1;
        end while (!rv && lat < 20);
        if (!rv) chk("rsp_timeout", 0, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_ack", {busy, rdy}, 2'b01);
    endtask

    initial begin
        #12;
        chk("rst_req_ready", {rdy1, rdy3}, 2'b11);
        chk("rst_busy_valid", {busy1, busy3, rv1, rv3, oe1, oe3, err1, err3}, 0);
        chk("rst_data", {mop1_1, ev1, od1}, 0);
        chk("rst_tag", {tg1, tg3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // both passes, LAT=1
        accept(64'h0304_0000_0000_0000, 64'h0506_0000_0000_0000, 2'b00, 2'b10, 5'h1A);
        wait_rsp();
        chk("both_lat", lat, 3);
        chk("both_oe_hist", oe_hist[3:1], 3'b010);
        chk("both_even", ev, 64'h000F_0000_0000_0000);
        chk("both_odd", od, 64'h0018_0000_0000_0000);
        chk("both_tag_err", {tg, err}, {5'h1A, 1'b0});
        ack();
        // odd only, 32-bit lanes
        accept(64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 2'b10, 2'b01, 5'h03);
        wait_rsp();
        chk("odd_lat", lat, 2);
        chk("odd_odd", od, 64'h0000_0001_0000_0000);
        chk("odd_even", ev, 0);
        chk("odd_tag_err", {tg, err}, {5'h03, 1'b0});
        ack();
        // illegal width
        accept(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 2'b11, 2'b00, 5'h07);
        wait_rsp();
        chk("ill_ww_lat", lat, 1);
        chk("ill_ww_err", err, 1);
        chk("ill_ww_res", {ev, od}, 0);
        chk("ill_ww_oe", oe_hist, 0);
        ack();
        // illegal mode
        accept(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 2'b00, 2'b11, 5'h08);
        wait_rsp();
        chk("ill_mode_lat", lat, 1);
        chk("ill_mode_err_res", {err, ev, od}, {1'b1, 128'h0});
        ack();
        // backpressure with LAT=3
        sel = 1'b1;
        accept(64'h0102_0304_0506_0708, 64'h0202_0202_0202_0202, 2'b00, 2'b10, 5'h15);
        wait_rsp();
        chk("bp_lat", lat, 7);
        chk("bp_oe_hist", oe_hist[7:1], 7'b0111000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_even", ev, 64'h0002_0006_000A_000E);
            chk("bp_odd", od, 64'h0004_0008_000C_0010);
            chk("bp_hold", {rv, rdy, tg, err}, {1'b1, 1'b0, 5'h15, 1'b0});
            @(negedge clk);
        end
        ack();
        accept(64'h0003_0000_0000_0000, 64'h0007_0000_0000_0000, 2'b01, 2'b00, 5'h02);
        wait_rsp();
        chk("bp_next_lat", lat, 4);
        chk("bp_next_even", ev, 64'h0000_0015_0000_0000);
        chk("bp_next_odd", od, 0);
        ack();
        // reset during the ODD pass
        accept(64'h0102_0304_0506_0708, 64'h0202_0202_0202_0202, 2'b00, 2'b10, 5'h09);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!oe && lat < 20);
        chk("rst_mid_reached_odd", {oe, ev}, {1'b1, 64'h0002_0006_000A_000E});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {rv, busy, rdy, oe}, 4'b0010);
        chk("rst_mid_res", {ev, od, tg, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(64'h0900_0000_0000_0000, 64'h0900_0000_0000_0000, 2'b00, 2'b00, 5'h11);
        wait_rsp();
        chk("rst_after_lat", lat, 4);
        chk("rst_after_res", {ev, od, tg}, {64'h0051_0000_0000_0000, 64'h0, 5'h11});
        ack();
        // request pulsed while busy must be ignored
        sel = 1'b0;
        accept(64'h0304_0000_0000_0000, 64'h0506_0000_0000_0000, 2'b00, 2'b10, 5'h0C);
        op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'h0202_0202_0202_0202; ww = 2'b10; mode = 2'b01; tag = 5'h1F;
        rv_in = 1'b1;
        wait_rsp();
        rv_in = 1'b0;
        chk("nr_lat", lat, 3);
        chk("nr_even", ev, 64'h000F_0000_0000_0000);
        chk("nr_odd", od, 64'h0018_0000_0000_0000);
        chk("nr_tag", tg, 5'h0C);
        ack();
        chk("nr_no_second", busy, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
